// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - pipelined floating-point adder/subtractor, 4 stages, valid/ready
//
// Purpose : res = op_1 + op_2 (sub=0) or op_1 - op_2 (sub=1) in a {sign, exp, frac}
//           format with EXP_W exponent bits and MAN_W fraction bits (hidden bit implicit).
//           Denormal inputs read as zero, underflow flushes to signed zero, overflow
//           clamps to infinity.
// Macro   : FP_ROUND_NEAREST_EN - defined: round-to-nearest-even; undefined: truncation.
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous active-low reset
//           en       - operand pair valid, captured when en && in_rdy
//           in_rdy   - pipeline accepts an operand pair this cycle
//           sub      - 0 add, 1 subtract
//           op_1     - operand A
//           op_2     - operand B
//           res      - result
//           val      - result valid
//           out_rdy  - downstream accepts res this cycle
//           ovf      - result overflowed to infinity (qualified by val)
//           zero     - result is exact zero (qualified by val)
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic                   in_rdy,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   op_1,
  input  logic [EXP_W+MAN_W:0]   op_2,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   val,
  input  logic                   out_rdy,
  output logic                   ovf,
  output logic                   zero
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 1;          // significand incl. hidden bit
  localparam int DW  = MAN_W + 4;          // hidden, frac, guard, round, sticky
  localparam int LZW = $clog2(DW + 1);
  localparam logic [EXP_W-1:0] DW_E = EXP_W'(DW);
  localparam logic [EXP_W:0]   EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // A stall freezes every stage; bubbles flow freely whenever S4 is empty.
  logic w_stall;
  assign w_stall = val & ~out_rdy;
  assign in_rdy  = ~w_stall;

  // ---------------- S1: unpack / swap ----------------
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MW-1:0]    w_a_man, w_b_man;
  logic             w_b_sign, w_swap;
  assign w_a_exp  = op_1[W-2:MAN_W];
  assign w_b_exp  = op_2[W-2:MAN_W];
  // exp == 0 zeroes the whole significand, so denormals compare and add as zero
  assign w_a_man  = (w_a_exp != '0) ? {1'b1, op_1[MAN_W-1:0]} : '0;
  assign w_b_man  = (w_b_exp != '0) ? {1'b1, op_2[MAN_W-1:0]} : '0;
  assign w_b_sign = op_2[W-1] ^ sub;
  assign w_swap   = {w_b_exp, w_b_man} > {w_a_exp, w_a_man};

  logic             r1_v, r1_sign_l, r1_sign_s;
  logic [EXP_W-1:0] r1_exp_l, r1_diff;
  logic [MW-1:0]    r1_man_l, r1_man_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_v <= 1'b0; r1_sign_l <= 1'b0; r1_sign_s <= 1'b0;
      r1_exp_l <= '0; r1_diff <= '0; r1_man_l <= '0; r1_man_s <= '0;
    end else if (!w_stall) begin
      r1_v      <= en;
      r1_sign_l <= w_swap ? w_b_sign : op_1[W-1];
      r1_sign_s <= w_swap ? op_1[W-1] : w_b_sign;
      r1_exp_l  <= w_swap ? w_b_exp : w_a_exp;
      r1_diff   <= w_swap ? (w_b_exp - w_a_exp) : (w_a_exp - w_b_exp);
      r1_man_l  <= w_swap ? w_b_man : w_a_man;
      r1_man_s  <= w_swap ? w_a_man : w_b_man;
    end
  end

  // ---------------- S2: align ----------------
  // Shift into a double-width window; the lower half holds every bit shifted past
  // and is folded into sticky. Clamping the amount keeps far-out bits in that window.
  logic [EXP_W-1:0] w_amt;
  logic [2*DW-1:0]  w_wide;
  logic [DW-1:0]    w_align;
  assign w_amt   = (r1_diff > DW_E) ? DW_E : r1_diff;
  assign w_wide  = {r1_man_s, 3'b000, {DW{1'b0}}} >> w_amt;
  assign w_align = w_wide[2*DW-1:DW] | {{(DW-1){1'b0}}, |w_wide[DW-1:0]};

  logic             r2_v, r2_sign, r2_sub;
  logic [EXP_W-1:0] r2_exp;
  logic [DW-1:0]    r2_man_l, r2_man_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r2_v <= 1'b0; r2_sign <= 1'b0; r2_sub <= 1'b0;
      r2_exp <= '0; r2_man_l <= '0; r2_man_s <= '0;
    end else if (!w_stall) begin
      r2_v     <= r1_v;
      r2_sign  <= r1_sign_l;
      r2_sub   <= r1_sign_l ^ r1_sign_s;
      r2_exp   <= r1_exp_l;
      r2_man_l <= {r1_man_l, 3'b000};
      r2_man_s <= w_align;
    end
  end

  // ---------------- S3: add / normalise ----------------
  // |A| >= |B| after the swap, so the subtraction never goes negative.
  logic [DW:0]      w_sum;
  logic [LZW-1:0]   w_lzc;
  logic [DW-1:0]    w_norm;
  logic [EXP_W:0]   w_nexp;
  logic             w_nzero, w_nsign;

  always_comb begin
    w_sum = r2_sub ? ({1'b0, r2_man_l} - {1'b0, r2_man_s})
                   : ({1'b0, r2_man_l} + {1'b0, r2_man_s});
    w_lzc = LZW'(DW);
    for (int i = 0; i < DW; i++) begin
      if (w_sum[i]) w_lzc = LZW'(DW - 1 - i);
    end
    w_norm  = '0;
    w_nexp  = '0;
    w_nzero = 1'b0;
    w_nsign = r2_sign;
    if (w_sum[DW]) begin
      // carry out: the bit dropped on the right shift stays in sticky
      w_norm = {w_sum[DW:2], w_sum[1] | w_sum[0]};
      w_nexp = {1'b0, r2_exp} + (EXP_W+1)'(1);
    end else if (w_sum == '0) begin
      w_nzero = 1'b1;       // exact cancellation is +0
      w_nsign = 1'b0;
    end else if ({1'b0, r2_exp} <= (EXP_W+1)'(w_lzc)) begin
      w_nzero = 1'b1;       // underflow keeps the sign
    end else begin
      w_norm = w_sum[DW-1:0] << w_lzc;
      w_nexp = {1'b0, r2_exp} - (EXP_W+1)'(w_lzc);
    end
  end

  logic             r3_v, r3_sign, r3_zero;
  logic [EXP_W:0]   r3_exp;
  logic [DW-1:0]    r3_man;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r3_v <= 1'b0; r3_sign <= 1'b0; r3_zero <= 1'b0; r3_exp <= '0; r3_man <= '0;
    end else if (!w_stall) begin
      r3_v    <= r2_v;
      r3_sign <= w_nsign;
      r3_zero <= w_nzero;
      r3_exp  <= w_nexp;
      r3_man  <= w_norm;
    end
  end

  // ---------------- S4: round / pack ----------------
  logic [MAN_W-1:0] w_frac4;
  logic [EXP_W:0]   w_exp4;
`ifdef FP_ROUND_NEAREST_EN
  logic             w_inc;
  logic [MW:0]      w_rnd;
  assign w_inc   = r3_man[2] & (r3_man[1] | r3_man[0] | r3_man[3]);
  assign w_rnd   = {1'b0, r3_man[DW-1:3]} + {{MW{1'b0}}, w_inc};
  // a round carry leaves 10...0, renormalise by one
  assign w_frac4 = w_rnd[MW] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
  assign w_exp4  = r3_exp + {{EXP_W{1'b0}}, w_rnd[MW]};
`else
  logic             w_unused_grs;
  assign w_unused_grs = ^{r3_man[DW-1], r3_man[2:0]};
  assign w_frac4 = r3_man[DW-2:3];
  assign w_exp4  = r3_exp;
`endif

  logic [W-1:0] w_res4;
  logic         w_ovf4, w_zero4;
  always_comb begin
    w_ovf4  = 1'b0;
    w_zero4 = 1'b0;
    if (r3_zero) begin
      w_res4  = {r3_sign, {(W-1){1'b0}}};
      w_zero4 = 1'b1;
    end else if (w_exp4 >= EXP_MAX) begin
      w_res4  = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf4  = 1'b1;
    end else begin
      w_res4  = {r3_sign, w_exp4[EXP_W-1:0], w_frac4};
    end
  end

  logic         r_val, r_ovf, r_zero;
  logic [W-1:0] r_res;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val <= 1'b0; r_ovf <= 1'b0; r_zero <= 1'b0; r_res <= '0;
    end else if (!w_stall) begin
      r_val  <= r3_v;
      r_res  <= w_res4;
      r_ovf  <= w_ovf4;
      r_zero <= w_zero4;
    end
  end

  assign val  = r_val;
  assign res  = r_res;
  assign ovf  = r_ovf;
  assign zero = r_zero;
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - self-checking bench for fp_add_pipe (default 8/23 format)
module tb_fp_add_pipe;
  logic        clk = 1'b0;
  logic        reset, en, sub, out_rdy;
  logic        in_rdy, val, ovf, zero;
  logic [31:0] op_1, op_2, res;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk(clk), .reset(reset), .en(en), .in_rdy(in_rdy), .sub(sub),
    .op_1(op_1), .op_2(op_2), .res(res), .val(val), .out_rdy(out_rdy),
    .ovf(ovf), .zero(zero)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        o;
    logic        z;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction: checks latency (4 edges incl. the accepting one) and outputs.
  task automatic run_one(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    en = 1'b1; op_1 = v.a; op_2 = v.b; sub = v.s;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    lat = 1;
    while (!val && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, lat, 4);
    chk({name, " res"}, res, v.r);
    chk({name, " ovf"}, {31'b0, ovf}, {31'b0, v.o});
    chk({name, " zero"}, {31'b0, zero}, {31'b0, v.z});
  endtask

  vec_t vecs[14];
  vec_t strm[6];

  initial begin
    logic [31:0] rnd_sticky;
    int   sent, rcv, cyc, extra;
    logic held_v;
    logic [31:0] held_r;
    logic saw_val;

`ifdef FP_ROUND_NEAREST_EN
    rnd_sticky = 32'h3F800001;
`else
    rnd_sticky = 32'h3F800000;
`endif
    //            a             b             s     r             o     z
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0}; // 1+1
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b1}; // 1.5-1.5
    vecs[2]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0}; // 3-1
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0}; // max+max
    vecs[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, rnd_sticky,   1'b0, 1'b0}; // G=R=1
    vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0}; // tie, even
    vecs[6]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b1}; // 1+(-1)
    vecs[7]  = '{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 1'b0, 1'b0}; // 2-3
    vecs[8]  = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0}; // denorm+1
    vecs[9]  = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 1'b0, 1'b0}; // 1-(-1)
    vecs[10] = '{32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0, 1'b0}; // .5+.25
    vecs[11] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1}; // underflow
    vecs[12] = '{32'h3F800000, 32'h33A00000, 1'b0, rnd_sticky,   1'b0, 1'b0}; // G=S=1
    vecs[13] = '{32'hBFC00000, 32'hC0200000, 1'b0, 32'hC0800000, 1'b0, 1'b0}; // -1.5-2.5

    strm[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
    strm[1] = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0};
    strm[2] = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0};
    strm[3] = '{32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0, 1'b0};
    strm[4] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0};
    strm[5] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b1};

    // reset state
    reset = 1'b0; en = 1'b0; sub = 1'b0; out_rdy = 1'b1; op_1 = '0; op_2 = '0;
    repeat (2) @(negedge clk);
    chk("reset val", {31'b0, val}, 32'd0);
    chk("reset res", res, 32'd0);
    chk("reset ovf/zero", {30'b0, ovf, zero}, 32'd0);
    chk("reset in_rdy", {31'b0, in_rdy}, 32'd1);
    reset = 1'b1;

    // directed vectors
    for (int i = 0; i < 14; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // stream of 6 with a 3-cycle downstream stall
    @(negedge clk);
    sent = 0; rcv = 0; held_v = 1'b0; held_r = '0;
    for (cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_rdy = !(cyc >= 6 && cyc < 9);
      #1;
      if (held_v) chk($sformatf("stream hold c%0d", cyc), res, held_r);
      if (cyc >= 6 && cyc < 9) chk($sformatf("stream in_rdy c%0d", cyc), {31'b0, in_rdy}, 32'd0);
      if (val && out_rdy) begin
        chk($sformatf("stream res%0d", rcv), res, strm[rcv].r);
        rcv++;
      end
      held_v = val && !out_rdy;
      held_r = res;
      if (sent < 6) begin
        en = 1'b1; op_1 = strm[sent].a; op_2 = strm[sent].b; sub = strm[sent].s;
        #1;
        if (in_rdy) sent++;
      end else begin
        en = 1'b0;
      end
    end
    chk("stream count", rcv, 6);
    en = 1'b0; out_rdy = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (val) extra++;
    end
    chk("stream no duplicate", extra, 0);

    // reset mid-flight discards two accepted pairs
    @(negedge clk);
    en = 1'b1; op_1 = 32'h3F800000; op_2 = 32'h3F800000; sub = 1'b0;
    @(negedge clk);
    op_1 = 32'h40400000; op_2 = 32'h3F800000;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset val", {31'b0, val}, 32'd0);
    chk("midreset res", res, 32'd0);
    @(negedge clk);
    chk("midreset outs", {res[31:2], ovf | res[1], zero | res[0]}, 32'd0);
    reset = 1'b1;
    saw_val = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (val) saw_val = 1'b1;
    end
    chk("midreset no val", {31'b0, saw_val}, 32'd0);
    run_one(vecs[2], "post-reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the successor to the fixed 32-bit adder.
- Generalised in exponent/mantissa width.
- Adds a subtract mode and output backpressure (valid/ready).
- Adds overflow/zero flags.
- Sits between operand-issue logic and the result writeback in the FP datapath.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa (fraction) width; hidden bit implicit
W = 1+EXP_W+MAN_W, derived localparam, operand/result width

Ports:
clk  input  1  clock, all flops rising-edge
reset  input  1  asynchronous, active-low reset
en  input  1  input valid; operands captured when en && in_rdy
in_rdy  output  1  pipeline can accept an operand pair this cycle
sub  input  1  0: res = op_1+op_2; 1: res = op_1-op_2
op_1  input  W  operand A {sign, exp, frac}
op_2  input  W  operand B
res  output  W  result
val  output  1  res valid
out_rdy  input  1  downstream accepts res this cycle
ovf  output  1  result overflowed to infinity (qualified by val)
zero  output  1  result is exact zero (qualified by val)

Behaviour:
- Reset (reset low, async): all stage valid bits, val, ovf and zero clear to 0; res clears to 0. in_rdy is 1 after reset.
- Pipeline has 4 registered stages; latency is 4 cycles from the accepting edge to val high with no stall.
  - S1 unpack/swap: effective sign of B is sign^sub. Order operands so |A| >= |B| (compare exp, then frac). Compute exponent difference.
  - S2 align: shift B mantissa right by the difference into a MAN_W+4 datapath (hidden, frac, guard, round, sticky). Sticky is the OR of all bits shifted past. A difference >= MAN_W+3 leaves only sticky.
  - S3 add/normalise: add or subtract the mantissas per the effective signs.
    - On carry-out: shift right 1, exp+1.
    - Otherwise: count leading zeros, shift left, exp-LZC.
    - Exp underflow (<=0) flushes to signed zero.
  - S4 round/pack: rounding per Optional Feature. A round carry renormalises (exp+1). Exp reaching all-ones gives ±inf (frac 0) with ovf=1.
- Operand rules:
  - Denormal inputs (exp=0) are treated as zero.
  - Exact cancellation yields +0 (sign 0) with zero=1.
  - Inputs with exp all-ones are not specially decoded: they are handled as ordinary magnitudes and clamp to inf on overflow.
- Handshake:
  - A stall occurs when val && !out_rdy. On stall, every stage holds; nothing advances.
  - in_rdy = !stall. Operands presented with en && !in_rdy are not captured; the source must hold them.
  - Empty bubbles advance even while downstream is not ready, provided S4 is empty.
  - Full throughput is one result per cycle when out_rdy stays high.
  - res/ovf/zero are held stable while val && !out_rdy.
- Reset mid-operation discards all in-flight results. No val is produced for operands accepted before reset.

Optional Feature:
Macro FP_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment when guard && (round || sticky || lsb).
- Undefined: truncation (round toward zero). Guard/round/sticky are dropped and the S4 incrementer is omitted.
- Latency and handshake are identical in both builds.

Test Plan:
1. Default params: en=1, op_1=0x3F800000, op_2=0x3F800000, sub=0, out_rdy=1 -> 4 cycles later val=1, res=0x40000000, ovf=0, zero=0.
2. op_1=0x3FC00000, op_2=0x3FC00000, sub=1 -> res=0x00000000, zero=1. Also op_1=0x40400000 (3.0), op_2=0x3F800000, sub=1 -> res=0x40000000.
3. op_1=op_2=0x7F7FFFFF, sub=0 -> res=0x7F800000, ovf=1.
4. Rounding:
   - op_1=0x3F800000, op_2=0x33C00000 -> with FP_ROUND_NEAREST_EN res=0x3F800001; without it res=0x3F800000.
   - op_2=0x33800000 (exact tie) -> res=0x3F800000 in both builds.
5. Stream 6 back-to-back pairs, out_rdy low for 3 cycles mid-stream -> in_rdy drops the same cycles, res held stable. All 6 results arrive in order, none lost or duplicated.
6. Issue 2 pairs, assert reset low 2 cycles later, release -> no val for either pair; outputs are 0 during reset; next pair after release returns correctly 4 cycles after acceptance.
